iter_muldiv_unit: RTL

//  Parametrised iterative multiply/divide engine for the multicycle CPU datapath; one radix-2 step per cycle.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/iter_muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine:
// operation codes and the control FSM states.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIXUP,
      DONE
   } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; acts as abs() when
// neg is driven by the operand's own sign bit.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   input  logic             neg,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/iter_muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine producing HI/LO
// with a start/busy/done handshake and synchronous abort.
module iter_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             abort,
   input  logic [WIDTH-1:0] opr_a,
   input  logic [WIDTH-1:0] opr_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic accept;
   logic is_signed;
   logic is_div;
   logic sign_a;
   logic sign_b;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   assign accept    = start && !abort
                    && (state == IDLE || state == DONE);
   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
   assign sign_a    = is_signed & a_q[WIDTH-1];
   assign sign_b    = is_signed & b_q[WIDTH-1];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .din  (a_q),
      .neg  (sign_a),
      .dout (abs_a)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .din  (b_q),
      .neg  (sign_b),
      .dout (abs_b)
   );

   muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .din  ({hi_q, lo_q}),
      .neg  (sign_a ^ sign_b),
      .dout (prod_fix)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
      .din  (lo_q),
      .neg  (sign_a ^ sign_b),
      .dout (quo_fix)
   );

   // Remainder follows the dividend's sign (truncating division).
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .din  (hi_q),
      .neg  (sign_a),
      .dout (rem_fix)
   );

   assign mul_sum   = {1'b0, hi_q}
                    + (lo_q[0] ? {1'b0, d_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, d_q};
   assign div_diff  = div_shift[WIDTH-1:0] - d_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = CALC;
            CALC:    state_nx = (cnt == CNT_W'(1)) ? FIXUP : CALC;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = start ? PREP : IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         PREP, CALC, FIXUP: busy = 1'b1;
         DONE:              done = 1'b1;
         default:           ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         d_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op;
            a_q  <= opr_a;
            b_q  <= opr_b;
         end
         case (state)
            PREP: begin
               hi_q <= '0;
               lo_q <= abs_a;
               d_q  <= abs_b;
               cnt  <= CNT_W'(WIDTH);
            end
            CALC: begin
               cnt <= cnt - CNT_W'(1);
               if (is_div) begin
                  hi_q <= div_ge ? div_diff
                                 : div_shift[WIDTH-1:0];
                  lo_q <= {lo_q[WIDTH-2:0], div_ge};
               end else begin
                  hi_q <= mul_sum[WIDTH:1];
                  lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
               end
            end
            FIXUP: begin
               if (!abort) begin
                  if (!is_div) begin
                     {result_hi, result_lo} <= prod_fix;
                     div_by_zero <= 1'b0;
                  end else if (d_q == '0) begin
                     result_hi   <= a_q;
                     result_lo   <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     result_hi   <= rem_fix;
                     result_lo   <= quo_fix;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
